// File: rtl/jt12_gainlim_pkg.sv
// Shared types and sizing helpers for the jt12_gainlim limiter.
package jt12_gainlim_pkg;

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic int gw_of(input int maxshift);
    return $clog2(maxshift + 1);
  endfunction

  // Counter width that stays at least one bit for degenerate HOLD/RAMP of 1.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jt12_gainlim_sat.sv
// One channel of shift-and-saturate: combinational, no backpressure.
// Clips when any bit shifted into or through the sign position differs from the sign.
module jt12_gainlim_sat
  import jt12_gainlim_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAXSHIFT = 7,
  localparam int GW      = gw_of(MAXSHIFT)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [GW-1:0]    g,
  output logic [WIDTH-1:0] y,
  output logic             clip
);

  always_comb begin
    clip = 1'b0;
    for (int k = 1; k <= MAXSHIFT; k++) begin
      if ((k <= int'(g)) && (x[WIDTH-1-k] != x[WIDTH-1])) begin
        clip = 1'b1;
      end
    end
    if (clip) begin
      y = {x[WIDTH-1], {(WIDTH-1){~x[WIDTH-1]}}};
    end else begin
      y = x << g;
    end
  end

endmodule

// File: rtl/jt12_gainlim.sv
// N-channel limiting amplifier with clip-driven hold/ramp gain control.
// Latency 2 cycles from sample_valid to dout_valid; no backpressure, one sample per cycle.
module jt12_gainlim
  import jt12_gainlim_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CH       = 2,
  parameter int MAXSHIFT = 7,
  parameter int HOLD     = 64,
  parameter int RAMP     = 256,
  localparam int GW      = gw_of(MAXSHIFT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [CH*WIDTH-1:0] din,
  input  logic [GW-1:0]       gain_tgt,
  input  logic                clr_ovf,
  output logic [CH*WIDTH-1:0] dout,
  output logic                dout_valid,
  output logic [CH-1:0]       ovf,
  output logic [GW-1:0]       gain_cur,
  output logic                limiting
);

  localparam int HW = cw_of(HOLD);
  localparam int RW = cw_of(RAMP);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [RW-1:0] RAMP_TOP  = RW'(RAMP - 1);
  localparam logic [GW:0]   MAX_EXT   = (GW+1)'(MAXSHIFT);

  logic [CH*WIDTH-1:0] s1_dat_q, s1_dat_d;
  logic [GW-1:0]       s1_gain_q, s1_gain_d;
  logic                s1_vld_q, s1_vld_d;
  logic [CH*WIDTH-1:0] dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;
  logic [CH-1:0]       clip_q, clip_d;
  logic [CH-1:0]       ovf_q, ovf_d;
  logic [GW-1:0]       gain_q, gain_d;
  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [RW-1:0]       ramp_q, ramp_d;
  logic                limiting_q, limiting_d;

  logic [CH*WIDTH-1:0] sat_y;
  logic [CH-1:0]       sat_clip;
  logic [GW-1:0]       tgt;
  logic [GW-1:0]       gain_dec;
  logic                clip_any;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jt12_gainlim_sat #(
      .WIDTH   (WIDTH),
      .MAXSHIFT(MAXSHIFT)
    ) u_sat (
      .x   (s1_dat_q[i*WIDTH +: WIDTH]),
      .g   (s1_gain_q),
      .y   (sat_y[i*WIDTH +: WIDTH]),
      .clip(sat_clip[i])
    );
  end

  always_comb begin
    tgt      = ({1'b0, gain_tgt} > MAX_EXT) ? GW'(MAXSHIFT) : gain_tgt;
    clip_any = |clip_q;
    gain_dec = (gain_q != '0) ? (gain_q - GW'(1)) : gain_q;

    // Stage 1 latches the gain alongside the data so later gain moves never touch it.
    s1_vld_d   = sample_valid;
    s1_dat_d   = sample_valid ? din    : s1_dat_q;
    s1_gain_d  = sample_valid ? gain_q : s1_gain_q;

    dout_vld_d = s1_vld_q;
    dout_d     = s1_vld_q ? sat_y    : dout_q;
    clip_d     = s1_vld_q ? sat_clip : '0;

    ovf_d = ovf_q & ~{CH{clr_ovf}};
    if (dout_vld_q) begin
      ovf_d = ovf_d | clip_q;
    end

    gain_d  = gain_q;
    state_d = state_q;
    hold_d  = hold_q;
    ramp_d  = ramp_q;

    if (dout_vld_q) begin
      if (state_q == ST_TRACK) begin
        if (clip_any) begin
          gain_d  = gain_dec;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end else if (gain_q > tgt) begin
          gain_d = gain_q - GW'(1);
          ramp_d = '0;
        end else if (gain_q < tgt) begin
          if (ramp_q == RAMP_TOP) begin
            gain_d = gain_q + GW'(1);
            ramp_d = '0;
          end else begin
            ramp_d = ramp_q + RW'(1);
          end
        end else begin
          ramp_d = '0;
        end
      end else begin
        if (clip_any) begin
          gain_d = gain_dec;
          hold_d = HOLD_LOAD;
        end else begin
          // While holding, gain may still follow a lowered target but never rises.
          if (gain_q > tgt) begin
            gain_d = gain_q - GW'(1);
          end
          if (hold_q == '0) begin
            state_d = ST_TRACK;
            ramp_d  = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
    end

    limiting_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_dat_q   <= '0;
      s1_gain_q  <= '0;
      s1_vld_q   <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      clip_q     <= '0;
      ovf_q      <= '0;
      gain_q     <= '0;
      state_q    <= ST_TRACK;
      hold_q     <= '0;
      ramp_q     <= '0;
      limiting_q <= 1'b0;
    end else begin
      s1_dat_q   <= s1_dat_d;
      s1_gain_q  <= s1_gain_d;
      s1_vld_q   <= s1_vld_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      clip_q     <= clip_d;
      ovf_q      <= ovf_d;
      gain_q     <= gain_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      ramp_q     <= ramp_d;
      limiting_q <= limiting_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_vld_q;
  assign ovf        = ovf_q;
  assign gain_cur   = gain_q;
  assign limiting   = limiting_q;

endmodule

// File: doc/jt12_gainlim.md
# jt12_gainlim

Parametrised N-channel limiting amplifier with automatic gain control. Applies a left shift (6 dB per step) to each channel and saturates any overflow to full scale. A hold/ramp controller backs the gain off on clipping and returns it slowly to a programmed target. Sits between the channel mixer/accumulator and the output DAC/resampler.

## Interface

**Parameters**
- `WIDTH`, 16: sample width per channel, two's complement.
- `CH`, 2: channel count.
- `MAXSHIFT`, 7: largest shift allowed; `GW = $clog2(MAXSHIFT+1)`.
- `HOLD`, 64: samples gain is frozen after a clip.
- `RAMP`, 256: clean samples per one-step gain increase.

**Ports**
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `sample_valid`, in, 1: `din` is valid this cycle. Back-to-back assertion is allowed.
- `din`, in, `CH*WIDTH`: packed samples; channel 0 in the LSBs.
- `gain_tgt`, in, `GW`: target shift. Values above `MAXSHIFT` are clamped to `MAXSHIFT`.
- `clr_ovf`, in, 1: clears the sticky overflow flags.
- `dout`, out, `CH*WIDTH`: limited samples, registered.
- `dout_valid`, out, 1: one-cycle pulse per processed sample.
- `ovf`, out, `CH`: sticky per-channel clip flags.
- `gain_cur`, out, `GW`: shift currently applied.
- `limiting`, out, 1: high while the controller is in the HOLD state.

## Operation

- **Stage 1**, on `sample_valid`: register `din` and capture `gain_cur` as `g1`. The captured gain applies to that sample whatever happens later.
- **Stage 2**, shift and saturate per channel with shift `g`:
  - Clip condition: `x[WIDTH-1 : WIDTH-1-g]` is not all equal.
  - On clip, output `{sign, {WIDTH-1{~sign}}}`. This gives `0x7FFF` for positive and `0x8000` for negative when `WIDTH=16`.
  - Otherwise output `x <<< g`.
  - Shift 0 never clips.
- **Gain controller** updates once per `dout_valid` cycle, using that sample's clip vector (`clip_any` = OR over channels) and the current `gain_tgt`.
  - **TRACK**:
    - If `clip_any`: `gain_cur` decrements (floor 0), `hold_cnt` loads `HOLD-1`, go to HOLD.
    - Else if `gain_cur > tgt`: `gain_cur` decrements, `ramp_cnt` clears.
    - Else if `gain_cur < tgt`: `ramp_cnt` increments. When it reaches `RAMP-1`, `gain_cur` increments and `ramp_cnt` clears.
    - Else: `ramp_cnt` clears.
  - **HOLD**:
    - If `clip_any`: `gain_cur` decrements (floor 0) and `hold_cnt` reloads.
    - Else if `hold_cnt == 0`: go to TRACK, `ramp_cnt` clears.
    - Else: `hold_cnt` decrements. Gain decreases toward `tgt` while in HOLD, but never increases.
  - Clip and `tgt < gain_cur` in the same update: decrement by exactly one.
- **Overflow flags**: `ovf[i]` sets on a channel-i clip at `dout_valid`. `clr_ovf` clears all flags; a same-cycle set wins over the clear.
- **Samples between stage 1 and stage 2**: a sample already captured in stage 1 when the gain changes keeps its old `g1`. No re-processing.

## Timing

- **Latency**: `dout`/`dout_valid` appear 2 cycles after the `sample_valid` edge (S1 register, then S2 register).
- **Gain update**: the new `gain_cur` is visible the cycle after `dout_valid`. It affects samples accepted from that cycle on. With back-to-back input, the sample captured on the `dout_valid` cycle uses the old gain.
- **`dout`** holds its value between pulses.
- **Reset values**:
  - `dout=0`, `dout_valid=0`, `ovf=0`.
  - `gain_cur=0`; this gives a soft start ramping up to target.
  - State TRACK, `hold_cnt=0`, `ramp_cnt=0`, `limiting=0`.
  - Pipeline valids cleared.
- **Reset mid-operation**: in-flight samples are dropped and no `dout_valid` is produced for them.
- **Counter widths**: `$clog2(HOLD)` and `$clog2(RAMP)`. Both counters saturate and never wrap.

## Structure

- **Package `jt12_gainlim_pkg`**: the state encoding (`ST_TRACK`, `ST_HOLD`) and a function computing `GW` from `MAXSHIFT`.
- **Sub-module `jt12_gainlim_sat`**: a combinational shift/saturate/clip-detect slice taking `WIDTH` and `MAXSHIFT`, instantiated `CH` times in a generate loop.
- **Top level**: the pipeline registers, the controller FSM and counters, and the `ovf` logic.

## Test plan

All scenarios use `WIDTH=16`, `CH=2`, `HOLD=4`, `RAMP=4`.

1. **Reset and soft start.** Reset, then `gain_tgt=2`, with 12 samples of `0x0100` on both channels.
   - `gain_cur` steps 0→1 after sample 4 and 1→2 after sample 8.
   - `dout` goes `0x0100`, then `0x0200`, then `0x0400`. `ovf=0`.
2. **Positive clip.** `gain_cur=2`, ch0=`0x3000`, ch1=`0x1000`.
   - ch0=`0x7FFF`, ch1=`0x4000`.
   - `ovf=01`, `gain_cur`→1, `limiting=1`.
3. **Negative clip and hold.** `gain_cur=2`, ch1=`0xC000`.
   - Saturates to `0x8000`.
   - Four clean samples follow at gain 1; then TRACK, and ramp back to 2 after 4 more samples.
4. **Clip in HOLD with target drop.** A clip during HOLD while `gain_tgt` drops below `gain_cur` on the same update.
   - Exactly one decrement; `hold_cnt` reloads.
   - Gain stays at 0 on repeated clips (floor).
5. **Back-to-back and latency.** `sample_valid` held high for 8 cycles.
   - `dout_valid` high 8 cycles, starting exactly 2 cycles later.
   - The sample accepted on the clip's `dout_valid` cycle uses the old gain.
6. **`ovf` races and reset.**
   - `clr_ovf` in the same cycle as a new clip: `ovf` stays set.
   - `rst_n=0` with a sample in flight: no `dout_valid` and all outputs at their reset values.
